// File: rtl/mips_fetch_pkg.sv
// Shared types and constants for the MIPS instruction fetch unit.
package mips_fetch_pkg;

  localparam int WORD_W = 32;
  localparam logic [WORD_W-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    HOLD  = 2'd2
  } fetchStateT;

endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-PC selection applied when decode accepts the held instruction.
module next_pc_calc
  import mips_fetch_pkg::*;
(
  input  logic [WORD_W-1:0] pcPlus4,
  input  logic              branch,
  input  logic              zero,
  input  logic              jump,
  input  logic [WORD_W-1:0] branchOffset,
  input  logic [25:0]       jumpIndex,
  output logic [WORD_W-1:0] nextPc
);

  // Jump wins over a taken branch; all arithmetic wraps modulo 2^32.
  always_comb begin
    nextPc = pcPlus4;
    if (jump) begin
      nextPc = {pcPlus4[31:28], jumpIndex, 2'b00};
    end else if (branch && zero) begin
      nextPc = pcPlus4 + (branchOffset << 2);
    end
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Single-outstanding instruction fetch: FETCH -> WAIT -> HOLD, one word per pass.
module instruction_fetch_unit
  import mips_fetch_pkg::*;
#(
  parameter logic [WORD_W-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        Branch,
  input  logic        Zero,
  input  logic        Jump,
  input  logic [31:0] branch_offset,
  input  logic [25:0] jump_index,
  input  logic        stall,
  output logic [31:0] instr,
  output logic [5:0]  OpCode,
  output logic [31:0] pc_plus4,
  output logic        instr_valid,
  output logic [1:0]  fsmState
);

  fetchStateT        state;
  logic [WORD_W-1:0] pc;
  logic [WORD_W-1:0] nextPc;

  next_pc_calc u_next_pc_calc (
    .pcPlus4      (pc_plus4),
    .branch       (Branch),
    .zero         (Zero),
    .jump         (Jump),
    .branchOffset (branch_offset),
    .jumpIndex    (jump_index),
    .nextPc       (nextPc)
  );

  // Handshakes: a request transfers on a cycle with imem_req && imem_ready;
  // its response is taken only in WAIT on imem_rvalid; decode accepts the
  // held word on a cycle with instr_valid && !stall.
  assign imem_req  = (state == FETCH) && rst_n;
  assign imem_addr = {pc[31:2], 2'b00};
  assign OpCode    = instr[31:26];
  assign fsmState  = state;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= FETCH;
      pc          <= RESET_PC;
      instr       <= '0;
      pc_plus4    <= '0;
      instr_valid <= 1'b0;
    end else begin
      case (state)
        FETCH: begin
          if (imem_ready) state <= WAIT;
        end
        WAIT: begin
          if (imem_rvalid) begin
            instr       <= imem_rdata;
            pc_plus4    <= {pc[31:2], 2'b00} + 32'd4;
            instr_valid <= 1'b1;
            state       <= HOLD;
          end
        end
        HOLD: begin
          if (!stall) begin
            instr_valid <= 1'b0;
            pc          <= nextPc;
            state       <= FETCH;
          end
        end
        default: state <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: sequential fetch, redirects, stall, backpressure, reset, wrap.
module tb_instruction_fetch_unit;
  import mips_fetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        Branch = 1'b0;
  logic        Zero = 1'b0;
  logic        Jump = 1'b0;
  logic [31:0] branch_offset = '0;
  logic [25:0] jump_index = '0;
  logic        stall = 1'b0;
  logic [31:0] instr;
  logic [5:0]  OpCode;
  logic [31:0] pc_plus4;
  logic        instr_valid;
  logic [1:0]  fsm_state;

  // second instance for the wrap-around case
  logic        rst2_n = 1'b0;
  logic        req2;
  logic [31:0] addr2;
  logic        ready2 = 1'b0;
  logic        rvalid2 = 1'b0;
  logic [31:0] rdata2 = '0;
  logic [31:0] instr2;
  logic [5:0]  opcode2;
  logic [31:0] pc_plus4_2;
  logic        valid2;
  logic [1:0]  fsm_state2;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  instruction_fetch_unit dut (
    .clk (clk), .rst_n (rst_n),
    .imem_req (imem_req), .imem_addr (imem_addr),
    .imem_ready (imem_ready), .imem_rvalid (imem_rvalid), .imem_rdata (imem_rdata),
    .Branch (Branch), .Zero (Zero), .Jump (Jump),
    .branch_offset (branch_offset), .jump_index (jump_index), .stall (stall),
    .instr (instr), .OpCode (OpCode), .pc_plus4 (pc_plus4),
    .instr_valid (instr_valid), .fsmState (fsm_state)
  );

  instruction_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk (clk), .rst_n (rst2_n),
    .imem_req (req2), .imem_addr (addr2),
    .imem_ready (ready2), .imem_rvalid (rvalid2), .imem_rdata (rdata2),
    .Branch (Branch), .Zero (Zero), .Jump (Jump),
    .branch_offset (branch_offset), .jump_index (jump_index), .stall (stall),
    .instr (instr2), .OpCode (opcode2), .pc_plus4 (pc_plus4_2),
    .instr_valid (valid2), .fsmState (fsm_state2)
  );

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Runs FETCH and WAIT for one word; returns at the negedge with the word held.
  task automatic do_fetch(input logic [31:0] addr, input logic [31:0] word);
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== addr) begin
      n_fail++;
      $display("FAIL fetch_req: req=%0b addr=%h, expected req=1 addr=%h", imem_req, imem_addr, addr);
    end
    n_checks++;
    if (instr_valid !== 1'b0 || fsm_state !== FETCH) begin
      n_fail++;
      $display("FAIL fetch_state: valid=%0b state=%0d, expected valid=0 state=%0d", instr_valid, fsm_state, FETCH);
    end
    imem_ready = 1'b1;
    tick();
    imem_ready = 1'b0;
    n_checks++;
    if (imem_req !== 1'b0 || fsm_state !== WAIT || instr_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL wait_state: req=%0b state=%0d valid=%0b, expected req=0 state=%0d valid=0", imem_req, fsm_state, instr_valid, WAIT);
    end
    imem_rvalid = 1'b1;
    imem_rdata  = word;
    tick();
    imem_rvalid = 1'b0;
    imem_rdata  = 32'hDEAD_BEEF;
    n_checks++;
    if (instr_valid !== 1'b1 || instr !== word || pc_plus4 !== addr + 32'd4 || fsm_state !== HOLD) begin
      n_fail++;
      $display("FAIL hold_word: valid=%0b instr=%h pc_plus4=%h state=%0d, expected valid=1 instr=%h pc_plus4=%h state=%0d",
               instr_valid, instr, pc_plus4, fsm_state, word, addr + 32'd4, HOLD);
    end
    n_checks++;
    if (OpCode !== word[31:26]) begin
      n_fail++;
      $display("FAIL opcode: got %h, expected %h", OpCode, word[31:26]);
    end
  endtask

  // Accepts the held word with the given control and checks the next request address.
  task automatic accept(input logic j, input logic b, input logic z,
                        input logic [31:0] off, input logic [25:0] idx, input logic [31:0] exp_next);
    Jump = j; Branch = b; Zero = z; branch_offset = off; jump_index = idx; stall = 1'b0;
    tick();
    Jump = 1'b0; Branch = 1'b0; Zero = 1'b0; branch_offset = '0; jump_index = '0;
    n_checks++;
    if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== exp_next) begin
      n_fail++;
      $display("FAIL accept_next: valid=%0b req=%0b addr=%h, expected valid=0 req=1 addr=%h", instr_valid, imem_req, imem_addr, exp_next);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) tick();
    n_checks++;
    if (imem_req !== 1'b0 || instr_valid !== 1'b0 || instr !== 32'h0 || pc_plus4 !== 32'h0 || fsm_state !== FETCH) begin
      n_fail++;
      $display("FAIL reset_values: req=%0b valid=%0b instr=%h pc_plus4=%h state=%0d, expected 0 0 0 0 %0d",
               imem_req, instr_valid, instr, pc_plus4, fsm_state, FETCH);
    end
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_first_req: req=%0b addr=%h, expected req=1 addr=00000000", imem_req, imem_addr);
    end
  endtask

  task automatic test_sequential;
    do_fetch(32'h0000_0000, 32'h2008_0001);
    accept(1'b0, 1'b0, 1'b0, 32'h0, 26'h0, 32'h0000_0004);
    do_fetch(32'h0000_0004, 32'h8C09_0004);
    accept(1'b0, 1'b0, 1'b0, 32'h0, 26'h0, 32'h0000_0008);
    do_fetch(32'h0000_0008, 32'hAC0A_0008);
    accept(1'b0, 1'b0, 1'b0, 32'h0, 26'h0, 32'h0000_000C);
  endtask

  task automatic test_branch;
    do_fetch(32'h0000_000C, 32'h0000_0020);
    accept(1'b0, 1'b0, 1'b0, 32'h0, 26'h0, 32'h0000_0010);
    do_fetch(32'h0000_0010, 32'h1000_FFFE);
    accept(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFE, 26'h0, 32'h0000_000C);
    do_fetch(32'h0000_000C, 32'h0000_0020);
    accept(1'b0, 1'b0, 1'b0, 32'h0, 26'h0, 32'h0000_0010);
    do_fetch(32'h0000_0010, 32'h1000_FFFE);
    accept(1'b0, 1'b1, 1'b0, 32'hFFFF_FFFE, 26'h0, 32'h0000_0014);
  endtask

  task automatic test_jump_priority;
    do_fetch(32'h0000_0014, 32'h1000_0000);
    // 0x18 + (0x0FFF_FFFB << 2) = 0x4000_0004
    accept(1'b0, 1'b1, 1'b1, 32'h0FFF_FFFB, 26'h0, 32'h4000_0004);
    do_fetch(32'h4000_0004, 32'h0800_0100);
    accept(1'b1, 1'b1, 1'b1, 32'h0000_0040, 26'h000_0100, 32'h4000_0400);
  endtask

  task automatic test_stall;
    do_fetch(32'h4000_0400, 32'h0123_4567);
    stall = 1'b1;
    Jump = 1'b1; Branch = 1'b1; Zero = 1'b1;
    branch_offset = 32'h0000_1234; jump_index = 26'h3AB_CDEF;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks++;
      if (instr !== 32'h0123_4567 || pc_plus4 !== 32'h4000_0404 || imem_req !== 1'b0 || instr_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL stall_hold[%0d]: instr=%h pc_plus4=%h req=%0b valid=%0b, expected 01234567 40000404 0 1",
                 i, instr, pc_plus4, imem_req, instr_valid);
      end
    end
    accept(1'b0, 1'b0, 1'b0, 32'h0, 26'h0, 32'h4000_0404);
  endtask

  task automatic test_backpressure;
    imem_ready  = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hBAD0_BAD0;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h4000_0404 || fsm_state !== FETCH || instr_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL backpressure[%0d]: req=%0b addr=%h state=%0d valid=%0b, expected 1 40000404 %0d 0",
                 i, imem_req, imem_addr, fsm_state, instr_valid, FETCH);
      end
    end
    imem_rvalid = 1'b0;
    do_fetch(32'h4000_0404, 32'h3C01_FFFF);
    accept(1'b0, 1'b0, 1'b0, 32'h0, 26'h0, 32'h4000_0408);
  endtask

  task automatic test_reset_mid_wait;
    imem_ready = 1'b1;
    tick();
    imem_ready = 1'b0;
    n_checks++;
    if (fsm_state !== WAIT) begin
      n_fail++;
      $display("FAIL midwait_enter: state=%0d, expected %0d", fsm_state, WAIT);
    end
    rst_n = 1'b0;
    tick();
    n_checks++;
    if (imem_req !== 1'b0 || fsm_state !== FETCH || instr_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL midwait_reset: req=%0b state=%0d valid=%0b, expected 0 %0d 0", imem_req, fsm_state, instr_valid, FETCH);
    end
    rst_n = 1'b1;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hBAD0_0001;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_checks++;
      if (instr_valid !== 1'b0 || instr !== 32'h0 || imem_req !== 1'b1 || imem_addr !== 32'h0 || fsm_state !== FETCH) begin
        n_fail++;
        $display("FAIL stale_rvalid[%0d]: valid=%0b instr=%h req=%0b addr=%h state=%0d, expected 0 00000000 1 00000000 %0d",
                 i, instr_valid, instr, imem_req, imem_addr, fsm_state, FETCH);
      end
    end
    imem_rvalid = 1'b0;
    do_fetch(32'h0000_0000, 32'h2008_0001);
    accept(1'b0, 1'b0, 1'b0, 32'h0, 26'h0, 32'h0000_0004);
  endtask

  task automatic test_wrap;
    rst2_n = 1'b1;
    #1;
    n_checks++;
    if (req2 !== 1'b1 || addr2 !== 32'hFFFF_FFFC) begin
      n_fail++;
      $display("FAIL wrap_first_req: req=%0b addr=%h, expected 1 fffffffc", req2, addr2);
    end
    ready2 = 1'b1;
    tick();
    ready2  = 1'b0;
    rvalid2 = 1'b1;
    rdata2  = 32'h0000_0000;
    tick();
    rvalid2 = 1'b0;
    n_checks++;
    if (valid2 !== 1'b1 || pc_plus4_2 !== 32'h0000_0000) begin
      n_fail++;
      $display("FAIL wrap_pc_plus4: valid=%0b pc_plus4=%h, expected 1 00000000", valid2, pc_plus4_2);
    end
    stall = 1'b0;
    tick();
    n_checks++;
    if (req2 !== 1'b1 || addr2 !== 32'h0000_0000 || valid2 !== 1'b0) begin
      n_fail++;
      $display("FAIL wrap_next: req=%0b addr=%h valid=%0b, expected 1 00000000 0", req2, addr2, valid2);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_sequential();
    test_branch();
    test_jump_priority();
    test_stall();
    test_backpressure();
    test_reset_mid_wait();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
